pc_fetch_ctrl: RTL and testbench

Program-counter controller for the basic control path. Holds the architectural PC and sequences instruction fetch via a req/ready handshake to instruction memory. Selects the next PC from sequential (PC+4), branch, jump or trap sources. Instantiates the existing pc_plus4 adder for the sequential path, and drives fetch-valid and flush signals to the decode stage.

---
 rtl/pc_ctrl_pkg.sv | 37 +++
 rtl/pc_plus4.sv | 23 ++
 rtl/pc_fetch_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pc_ctrl_pkg
// Shared types and constants for the program-counter fetch controller.
//   state_t      : fetch sequencer states (BOOT, FETCH, HOLD)
//   next_sel_t   : source selected for the next PC value
//   DEFAULT_*    : default reset and trap vectors
//   PC_STEP      : sequential instruction stride in bytes
//   is_misaligned: true when an address is not word aligned
// ---------------------------------------------------------------------------
package pc_ctrl_pkg;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Next-PC source encoding, in no particular priority order
  typedef enum logic [2:0] {
    SEL_HOLD   = 3'd0,
    SEL_SEQ    = 3'd1,
    SEL_BRANCH = 3'd2,
    SEL_JUMP   = 3'd3,
    SEL_TRAP   = 3'd4
  } next_sel_t;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;
  localparam logic [31:0] PC_STEP              = 32'd4;

  // Instructions are 32-bit words, so the two low address bits must be zero
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage : pc_ctrl_pkg

// File: rtl/pc_plus4.sv
// ---------------------------------------------------------------------------
// pc_plus4
// Sequential-path adder for the fetch controller. Produces pc + 4 with
// plain modulo-2^WIDTH wrap; no carry-out is reported.
//   pc       : input  [WIDTH-1:0] current program counter
//   pc_plus4 : output [WIDTH-1:0] pc + 4
// ---------------------------------------------------------------------------
module pc_plus4
  import pc_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4
);

  // Stride comes from the package so both blocks agree on instruction size
  localparam logic [WIDTH-1:0] STEP = WIDTH'(PC_STEP);

  // Wrap at the top of the address space is intentional and silent
  assign pc_plus4 = pc + STEP;

endmodule : pc_plus4

// File: rtl/pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl
// Holds the architectural PC and sequences instruction fetch through a
// req/ready handshake. The next PC is chosen from trap, jump, branch,
// hold or sequential (PC+4) sources; redirects raise a one-cycle flush so
// decode discards whatever instruction was fetched at the old PC.
//
// Ports
//   clk              : system clock, rising edge
//   rst              : asynchronous active-high reset
//   stall_i          : front-end stall, hold PC and drop the request
//   branch_taken_i   : conditional branch resolved taken this cycle
//   branch_target_i  : branch destination
//   jump_i           : unconditional jump this cycle
//   jump_target_i    : jump destination
//   imem_ready_i     : instruction memory accepts the request at pc_o
//   imem_req_o       : fetch request for address pc_o
//   pc_o             : current fetch PC (registered)
//   pc_plus4_o       : pc_o + 4
//   instr_valid_o    : fetch accepted this cycle (imem_req_o & imem_ready_i)
//   flush_o          : one-cycle pulse after any redirect
//   misalign_trap_o  : one-cycle pulse after a misaligned redirect target
// ---------------------------------------------------------------------------
module pc_fetch_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR,
  parameter int          XLEN         = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic            jump_i,
  input  logic [XLEN-1:0] jump_target_i,
  input  logic            imem_ready_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            instr_valid_o,
  output logic            flush_o,
  output logic            misalign_trap_o
);

  // Registered state and outputs
  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_imem_req;
  logic            r_flush;
  logic            r_trap;

  // Combinational next-PC decision
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_redirect_target;
  logic            w_redirect;
  logic            w_handshake;
  next_sel_t       w_sel;

  // Sequential adder lives in its own block so it can be shared elsewhere
  pc_plus4 #(
    .WIDTH (XLEN)
  ) u_pc_plus4 (
    .pc       (r_pc),
    .pc_plus4 (w_pc_plus4)
  );

  // The request flop is 1 exactly while in FETCH, so the handshake is
  // simply the registered request qualified by memory ready.
  assign w_handshake = r_imem_req & imem_ready_i;

  // Jump beats branch, so only the jump target is looked at when both fire.
  // Redirects are ignored in BOOT so the first fetch is always the reset
  // vector.
  assign w_redirect_target = jump_i ? jump_target_i : branch_target_i;
  assign w_redirect        = (r_state != BOOT) && (jump_i || branch_taken_i);

  // Next-PC priority: misaligned redirect, jump, branch, stall, accepted
  // fetch, otherwise hold while waiting on ready. A redirect overrides both
  // a stall and an unaccepted request; the old request is simply dropped.
  always_comb begin
    w_sel = SEL_HOLD;
    if (w_redirect) begin
      if (is_misaligned(32'(w_redirect_target))) begin
        w_sel = SEL_TRAP;
      end else if (jump_i) begin
        w_sel = SEL_JUMP;
      end else begin
        w_sel = SEL_BRANCH;
      end
    end else if ((r_state != BOOT) && stall_i) begin
      w_sel = SEL_HOLD;
    end else if (w_handshake) begin
      w_sel = SEL_SEQ;
    end
  end

  // Single sequencer: state, PC and the registered pulse outputs. Reset is
  // asynchronous so an in-flight request is abandoned immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= BOOT;
      r_pc       <= XLEN'(RESET_VECTOR);
      r_imem_req <= 1'b0;
      r_flush    <= 1'b0;
      r_trap     <= 1'b0;
    end else begin
      r_flush <= 1'b0;
      r_trap  <= 1'b0;

      case (w_sel)
        SEL_TRAP: begin
          r_pc    <= XLEN'(TRAP_VECTOR);
          r_trap  <= 1'b1;
          r_flush <= 1'b1;
        end
        SEL_JUMP: begin
          r_pc    <= jump_target_i;
          r_flush <= 1'b1;
        end
        SEL_BRANCH: begin
          r_pc    <= branch_target_i;
          r_flush <= 1'b1;
        end
        SEL_SEQ: begin
          r_pc <= w_pc_plus4;
        end
        default: begin
          r_pc <= r_pc;
        end
      endcase

      case (r_state)
        BOOT: begin
          r_state    <= FETCH;
          r_imem_req <= 1'b1;
        end
        FETCH, HOLD: begin
          // A redirect always lands in FETCH, even out of HOLD
          if (w_redirect) begin
            r_state    <= FETCH;
            r_imem_req <= 1'b1;
          end else if (stall_i) begin
            r_state    <= HOLD;
            r_imem_req <= 1'b0;
          end else begin
            r_state    <= FETCH;
            r_imem_req <= 1'b1;
          end
        end
        default: begin
          r_state    <= BOOT;
          r_imem_req <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_o      = r_imem_req;
  assign pc_o            = r_pc;
  assign pc_plus4_o      = w_pc_plus4;
  assign instr_valid_o   = w_handshake;
  assign flush_o         = r_flush;
  assign misalign_trap_o = r_trap;

endmodule : pc_fetch_ctrl

// File: tb/tb_pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_ctrl
// Directed bench for pc_fetch_ctrl. Each scenario task drives inputs just
// after a rising edge and checks outputs one time unit after the edge.
// ---------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic        jump_i;
  logic [31:0] jump_target_i;
  logic        imem_ready_i;
  logic        imem_req_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        instr_valid_o;
  logic        flush_o;
  logic        misalign_trap_o;

  int compared;
  int mismatched;

  pc_fetch_ctrl #(
    .RESET_VECTOR (32'h0000_0000),
    .TRAP_VECTOR  (32'h0000_0100),
    .XLEN         (32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .jump_i          (jump_i),
    .jump_target_i   (jump_target_i),
    .imem_ready_i    (imem_ready_i),
    .imem_req_o      (imem_req_o),
    .pc_o            (pc_o),
    .pc_plus4_o      (pc_plus4_o),
    .instr_valid_o   (instr_valid_o),
    .flush_o         (flush_o),
    .misalign_trap_o (misalign_trap_o)
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to one time unit past the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive all redirect/stall controls in one call
  task automatic applyStimulus(input logic st, input logic jmp, input logic [31:0] jt,
                               input logic br, input logic [31:0] bt, input logic rdy);
    stall_i         = st;
    jump_i          = jmp;
    jump_target_i   = jt;
    branch_taken_i  = br;
    branch_target_i = bt;
    imem_ready_i    = rdy;
  endtask

  // Reset state, then BOOT -> FETCH and sequential advance to 0x10
  task automatic test_reset();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step();
    step();
    compared++;
    if ({imem_req_o, flush_o, misalign_trap_o, instr_valid_o} !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL reset_ctrl: got %b, expected 0000", {imem_req_o, flush_o, misalign_trap_o, instr_valid_o});
    end
    compared++;
    if (pc_o !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_pc: got %h, expected 00000000", pc_o);
    end
    rst = 1'b0;
    step();
    compared++;
    if ({imem_req_o, instr_valid_o} !== 2'b11 || pc_o !== 32'h0 || pc_plus4_o !== 32'h4) begin
      mismatched++;
      $display("[TB] FAIL boot_exit: got req=%b vld=%b pc=%h p4=%h, expected req=1 vld=1 pc=0 p4=4",
               imem_req_o, instr_valid_o, pc_o, pc_plus4_o);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [4] = '{32'h4, 32'h8, 32'hC, 32'h10};
    for (int i = 0; i < 4; i++) begin
      step();
      compared++;
      if (pc_o !== exp_pc[i] || imem_req_o !== 1'b1 || flush_o !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL seq_%0d: got pc=%h req=%b flush=%b, expected pc=%h req=1 flush=0",
                 i, pc_o, imem_req_o, flush_o, exp_pc[i]);
      end
    end
  endtask

  // Wait states at 0x10, two stall cycles, then release
  task automatic test_wait_stall();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      compared++;
      if (pc_o !== 32'h10 || imem_req_o !== 1'b1 || instr_valid_o !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL wait_%0d: got pc=%h req=%b vld=%b, expected pc=00000010 req=1 vld=0",
                 i, pc_o, imem_req_o, instr_valid_o);
      end
    end
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      compared++;
      if (pc_o !== 32'h10 || imem_req_o !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL stall_%0d: got pc=%h req=%b, expected pc=00000010 req=0", i, pc_o, imem_req_o);
      end
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step();
    compared++;
    if (pc_o !== 32'h10 || imem_req_o !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL stall_release: got pc=%h req=%b, expected pc=00000010 req=1", pc_o, imem_req_o);
    end
    step();
    compared++;
    if (pc_o !== 32'h14) begin
      mismatched++;
      $display("[TB] FAIL post_stall_seq: got %h, expected 00000014", pc_o);
    end
  endtask

  // Jump beats branch; redirect coincides with an accepted fetch
  task automatic test_redirect();
    applyStimulus(1'b0, 1'b1, 32'h200, 1'b1, 32'h300, 1'b1);
    #1;
    compared++;
    if (instr_valid_o !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL redirect_old_valid: got %b, expected 1", instr_valid_o);
    end
    step();
    compared++;
    if (pc_o !== 32'h200 || flush_o !== 1'b1 || misalign_trap_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL jump_wins: got pc=%h flush=%b trap=%b, expected pc=00000200 flush=1 trap=0",
               pc_o, flush_o, misalign_trap_o);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step();
    compared++;
    if (pc_o !== 32'h204 || flush_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL jump_after: got pc=%h flush=%b, expected pc=00000204 flush=0", pc_o, flush_o);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h7708, 1'b1);
    step();
    compared++;
    if (pc_o !== 32'h7708 || flush_o !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL branch_only: got pc=%h flush=%b, expected pc=00007708 flush=1", pc_o, flush_o);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step();
    compared++;
    if (pc_o !== 32'h770C || flush_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL branch_after: got pc=%h flush=%b, expected pc=0000770c flush=0", pc_o, flush_o);
    end
  endtask

  task automatic test_misalign();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h7709, 1'b1);
    step();
    compared++;
    if (pc_o !== 32'h100 || flush_o !== 1'b1 || misalign_trap_o !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL misalign_trap: got pc=%h flush=%b trap=%b, expected pc=00000100 flush=1 trap=1",
               pc_o, flush_o, misalign_trap_o);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step();
    compared++;
    if (pc_o !== 32'h104 || flush_o !== 1'b0 || misalign_trap_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL misalign_pulse_end: got pc=%h flush=%b trap=%b, expected pc=00000104 flush=0 trap=0",
               pc_o, flush_o, misalign_trap_o);
    end
    // Aligned jump with misaligned branch: only the jump target matters
    applyStimulus(1'b0, 1'b1, 32'h208, 1'b1, 32'h7709, 1'b1);
    step();
    compared++;
    if (pc_o !== 32'h208 || flush_o !== 1'b1 || misalign_trap_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL jump_ignores_branch_align: got pc=%h flush=%b trap=%b, expected pc=00000208 flush=1 trap=0",
               pc_o, flush_o, misalign_trap_o);
    end
  endtask

  task automatic test_back_to_back();
    applyStimulus(1'b0, 1'b1, 32'h500, 1'b0, 32'h0, 1'b1);
    step();
    compared++;
    if (pc_o !== 32'h500 || flush_o !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL b2b_first: got pc=%h flush=%b, expected pc=00000500 flush=1", pc_o, flush_o);
    end
    applyStimulus(1'b0, 1'b1, 32'h602, 1'b0, 32'h0, 1'b1);
    step();
    compared++;
    if (pc_o !== 32'h100 || flush_o !== 1'b1 || misalign_trap_o !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL b2b_trap: got pc=%h flush=%b trap=%b, expected pc=00000100 flush=1 trap=1",
               pc_o, flush_o, misalign_trap_o);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h700, 1'b1);
    step();
    compared++;
    if (pc_o !== 32'h700 || flush_o !== 1'b1 || misalign_trap_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL b2b_third: got pc=%h flush=%b trap=%b, expected pc=00000700 flush=1 trap=0",
               pc_o, flush_o, misalign_trap_o);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step();
    compared++;
    if (pc_o !== 32'h704 || flush_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL b2b_end: got pc=%h flush=%b, expected pc=00000704 flush=0", pc_o, flush_o);
    end
  endtask

  // Address wrap, then a branch taken while in HOLD
  task automatic test_wrap_stall_redirect();
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1);
    step();
    compared++;
    if (pc_o !== 32'hFFFF_FFFC || pc_plus4_o !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL wrap_top: got pc=%h p4=%h, expected pc=fffffffc p4=00000000", pc_o, pc_plus4_o);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step();
    compared++;
    if (pc_o !== 32'h0 || flush_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL wrap_zero: got pc=%h flush=%b, expected pc=00000000 flush=0", pc_o, flush_o);
    end
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step();
    compared++;
    if (pc_o !== 32'h0 || imem_req_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL stall_enter: got pc=%h req=%b, expected pc=00000000 req=0", pc_o, imem_req_o);
    end
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1);
    step();
    compared++;
    if (pc_o !== 32'h40 || imem_req_o !== 1'b1 || flush_o !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL hold_redirect: got pc=%h req=%b flush=%b, expected pc=00000040 req=1 flush=1",
               pc_o, imem_req_o, flush_o);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step();
    compared++;
    if (pc_o !== 32'h44 || flush_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL hold_redirect_after: got pc=%h flush=%b, expected pc=00000044 flush=0", pc_o, flush_o);
    end
  endtask

  // Async reset mid-handshake, then a redirect held through BOOT
  task automatic test_async_reset();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step();
    compared++;
    if (pc_o !== 32'h44 || imem_req_o !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL pre_reset: got pc=%h req=%b, expected pc=00000044 req=1", pc_o, imem_req_o);
    end
    rst = 1'b1;
    #2;
    compared++;
    if (pc_o !== 32'h0 || imem_req_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL async_reset: got pc=%h req=%b, expected pc=00000000 req=0", pc_o, imem_req_o);
    end
    applyStimulus(1'b0, 1'b1, 32'h300, 1'b0, 32'h0, 1'b1);
    step();
    rst = 1'b0;
    step();
    compared++;
    if (pc_o !== 32'h0 || flush_o !== 1'b0 || imem_req_o !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL boot_ignores_redirect: got pc=%h flush=%b req=%b, expected pc=00000000 flush=0 req=1",
               pc_o, flush_o, imem_req_o);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_sequential();
    test_wait_stall();
    test_redirect();
    test_misalign();
    test_back_to_back();
    test_wrap_stall_redirect();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_pc_fetch_ctrl
